// File: rtl/matmul_feeder_if.sv
// MAC-array side bundle of the matmul feeder: operand streams,
// per-MAC load/clear strobes and the serial result unload path.
interface matmul_feeder_if;
  logic [3:0] data_w1;
  logic [3:0] data_w2;
  logic [3:0] data_w3;
  logic [3:0] data_x1;
  logic [3:0] data_x2;
  logic [3:0] data_x3;
  logic [8:0] load;
  logic [8:0] clear;
  logic       unload_res;
  logic [9:0] data_out;

  modport master (
    output data_w1, data_w2, data_w3,
    output data_x1, data_x2, data_x3,
    output load, clear, unload_res,
    input  data_out
  );

  modport slave (
    input  data_w1, data_w2, data_w3,
    input  data_x1, data_x2, data_x3,
    input  load, clear, unload_res,
    output data_out
  );
endinterface

// File: rtl/matmul_feeder.sv
// 3x3 matmul operand feeder / result collector for a MAC array.
// Optional sticky protocol-error flag: define MATMUL_FEEDER_ERR_EN.
module matmul_feeder #(
  parameter int UNLOAD_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic       wr_sel,
  input  logic [3:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic [3:0] rd_addr,
  output logic [9:0] rd_data,
  matmul_feeder_if.master mac
);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    FEED,
    UNLOAD,
    DONE
  } state_t;

  localparam logic [3:0] LAT  = 4'(UNLOAD_LAT);
  localparam logic [3:0] LAST = 4'(UNLOAD_LAT + 8);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  logic [3:0] w_mem [9];
  logic [3:0] x_mem [9];
  logic [9:0] r_mem [9];

  logic [3:0] k;
  logic [3:0] k3;
  logic [4:0] cap_diff;
  logic       cap;

  assign k  = {2'b00, cnt_q[1:0]};
  assign k3 = (k << 1) + k;

  // Capture window opens once the array's unload latency has elapsed.
  assign cap_diff = {1'b0, cnt_q} - {1'b0, LAT};
  assign cap      = (state_q == UNLOAD) && !cap_diff[4];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    busy           = 1'b0;
    done           = 1'b0;
    mac.load       = '0;
    mac.clear      = '0;
    mac.unload_res = 1'b0;
    mac.data_w1    = '0;
    mac.data_w2    = '0;
    mac.data_w3    = '0;
    mac.data_x1    = '0;
    mac.data_x2    = '0;
    mac.data_x3    = '0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLR;
          cnt_d   = '0;
        end
      end
      CLR: begin
        busy      = 1'b1;
        mac.clear = 9'h1FF;
        state_d   = FEED;
        cnt_d     = '0;
      end
      FEED: begin
        busy        = 1'b1;
        mac.load    = 9'h1FF;
        mac.data_w1 = w_mem[k];
        mac.data_w2 = w_mem[4'd3 + k];
        mac.data_w3 = w_mem[4'd6 + k];
        mac.data_x1 = x_mem[k3];
        mac.data_x2 = x_mem[k3 + 4'd1];
        mac.data_x3 = x_mem[k3 + 4'd2];
        if (cnt_q == 4'd2) begin
          state_d = UNLOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      UNLOAD: begin
        busy           = 1'b1;
        mac.unload_res = 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 9; i++) begin
        w_mem[i] <= '0;
        x_mem[i] <= '0;
        r_mem[i] <= '0;
      end
    end else begin
      if (state_q == IDLE && wr_en && wr_addr < 4'd9) begin
        if (wr_sel) x_mem[wr_addr] <= wr_data;
        else        w_mem[wr_addr] <= wr_data;
      end
      if (cap) r_mem[cap_diff[3:0]] <= mac.data_out;
    end
  end

  assign rd_data = (rd_addr < 4'd9) ? r_mem[rd_addr] : '0;

`ifdef MATMUL_FEEDER_ERR_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (reset)                        err_q <= 1'b0;
    else if (busy && (start || wr_en)) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/matmul_feeder.md
MATMUL_FEEDER -- requirements
Module: matmul_feeder

Interface
REQ-001 Parameter UNLOAD_LAT, default 1: cycles from unload_res rise to first valid data_out word; legal range 0..3.
REQ-002 The block SHALL use one clock and a synchronous active-high reset.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 wr_en  in  1  host write strobe for the operand store.
REQ-006 wr_sel  in  1  0 = W matrix, 1 = X matrix.
REQ-007 wr_addr  in  4  element index row*3+col, 0..8.
REQ-008 wr_data  in  4  unsigned operand element.
REQ-009 start  in  1  single-cycle run request.
REQ-010 busy  out  1  run in progress.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 err  out  1  sticky protocol-error flag.
REQ-013 data_w1, data_w2, data_w3  out  4 each  W column stream to the MAC array.
REQ-014 data_x1, data_x2, data_x3  out  4 each  X row stream to the MAC array.
REQ-015 load, clear  out  9 each  per-MAC accumulate enable and clear; bit index = (i-1)*3+(j-1).
REQ-016 unload_res  out  1  serial result unload request.
REQ-017 data_out  in  10  serial result word from the MAC array.
REQ-018 rd_addr  in  4  result buffer read index 0..8.
REQ-019 rd_data  out  10  combinational read of R[rd_addr]; 0 when rd_addr > 8.

Function
REQ-020 Storage: W[3][3] and X[3][3] at 4 bits each, plus R[9] at 10 bits each.
REQ-021 Writes: wr_en in IDLE writes wr_data to W or X at wr_addr; wr_addr 9..15 ignored; writes in any other state ignored.
REQ-022 FSM states: IDLE, CLR, FEED, UNLOAD, DONE.
REQ-023 IDLE->CLR on start; start is sampled only in IDLE.
REQ-024 CLR lasts 1 cycle: clear=9'h1FF, load=0.
REQ-025 FEED lasts 3 cycles, k=0,1,2: data_wi=W[i-1][k], data_xj=X[k][j-1], load=9'h1FF, clear=0.
REQ-026 UNLOAD lasts UNLOAD_LAT+9 cycles: unload_res=1; in UNLOAD cycle UNLOAD_LAT+n (n=0..8, counted from 0) data_out is captured into R[n].
REQ-027 DONE lasts 1 cycle: done=1, then DONE->IDLE.
REQ-028 busy=1 in CLR, FEED and UNLOAD; busy=0 in IDLE and DONE.
REQ-029 Outside FEED: data_w*/data_x* are 0 and load=0. Outside CLR: clear=0. Outside UNLOAD: unload_res=0.
REQ-030 Latency: with start sampled at edge 0, done is high in cycle 14+UNLOAD_LAT.
REQ-031 start in CLR, FEED or UNLOAD is ignored and the run continues unaffected; start in DONE is ignored.
REQ-032 R is overwritten only by a completed capture and holds its value across idle periods.

Reset
REQ-033 reset forces IDLE from any state, including mid-run, effective at the next edge.
REQ-034 Reset values: busy=0, done=0, err=0, load=0, clear=0, unload_res=0, all data_w*/data_x*=0, W=X=R=0.

Configuration
REQ-035 Macro MATMUL_FEEDER_ERR_EN: when defined, err is set by start while busy=1 or by wr_en while busy=1, and err clears only on reset.
REQ-036 When MATMUL_FEEDER_ERR_EN is not defined, err is tied to 0; the events in REQ-035 are still ignored per REQ-021 and REQ-031.

Verification
REQ-037 W=identity, X=1..9 row-major, UNLOAD_LAT=1, array model fed back -> R[0..8]=1..9, done in cycle 15, busy high in cycles 1..14.
REQ-038 All W and X elements = 15 -> every R[n]=675; load=9'h1FF for exactly 3 cycles.
REQ-039 start pulsed in FEED with macro defined -> run unchanged, err=1 and stays 1 until reset; without macro -> err stays 0.
REQ-040 reset asserted in the second FEED cycle -> next cycle IDLE, all outputs 0, rd_data=0 for rd_addr 0..8.
REQ-041 Write to wr_addr=12, and a write during UNLOAD -> W/X unchanged; rd_addr=12 -> rd_data=0.
REQ-042 UNLOAD_LAT=0 and 3 sweep -> captures shift accordingly, done in cycle 14 and 17 respectively.
